// File: rtl/phys_reg_free_list_if.sv
// Rename/retire/recovery connection to the physical register free list.
// The master side (rename, retire, recovery) drives requests, releases and
// rollback; the slave side (the free list) returns grants and its state.
interface phys_reg_free_list_if #(
    parameter int PHYS_REG_SZ      = 64,
    parameter int PHYS_REG_ID_BITS = 6,
    parameter int ALLOC_WIDTH      = 2,
    parameter int FREE_WIDTH       = 2
);
    logic [ALLOC_WIDTH-1:0]                  alloc_req;
    logic [ALLOC_WIDTH-1:0]                  alloc_grant;
    logic [ALLOC_WIDTH*PHYS_REG_ID_BITS-1:0] alloc_idx;
    logic [FREE_WIDTH-1:0]                   free_valid;
    logic [FREE_WIDTH*PHYS_REG_ID_BITS-1:0]  free_idx;
    logic                                    rollback;
    logic [PHYS_REG_SZ-1:0]                  rollback_map;
    logic [PHYS_REG_SZ-1:0]                  free_map;
    logic [PHYS_REG_ID_BITS:0]               free_count;
    logic                                    empty;
    logic                                    double_free_err;

    modport master (
        output alloc_req, free_valid, free_idx, rollback, rollback_map,
        input  alloc_grant, alloc_idx, free_map, free_count, empty, double_free_err
    );

    modport slave (
        input  alloc_req, free_valid, free_idx, rollback, rollback_map,
        output alloc_grant, alloc_idx, free_map, free_count, empty, double_free_err
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Bitmap free list for the physical register file. Grants hand out the
// highest-index free tags (lane 0 gets the highest), retire releases tags,
// and branch recovery reloads a checkpointed free map.
module phys_reg_free_list #(
    parameter int PHYS_REG_SZ      = 64,
    parameter int PHYS_REG_ID_BITS = 6,
    parameter int ARCH_REG_SZ      = 32,
    parameter int ALLOC_WIDTH      = 2,
    parameter int FREE_WIDTH       = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    phys_reg_free_list_if.slave  fl
);

    localparam int CNT_W = PHYS_REG_ID_BITS + 1;

    // Architectural tags start out mapped; everything above them is free.
    localparam logic [PHYS_REG_SZ-1:0] RESET_MAP =
        {{(PHYS_REG_SZ-ARCH_REG_SZ){1'b1}}, {ARCH_REG_SZ{1'b0}}};
    localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(PHYS_REG_SZ - ARCH_REG_SZ);

    logic [PHYS_REG_SZ-1:0]                  free_map_q, free_map_d;
    logic [CNT_W-1:0]                        free_count_q, free_count_d;
    logic                                    empty_q, empty_d;
    logic                                    dfe_q, dfe_d;

    logic [ALLOC_WIDTH-1:0]                  grant_c;
    logic [ALLOC_WIDTH*PHYS_REG_ID_BITS-1:0] idx_c;
    logic [PHYS_REG_SZ-1:0]                  granted_bits;
    logic [CNT_W-1:0]                        n_grant;

    logic [PHYS_REG_SZ-1:0]                  freed_bits;
    logic [CNT_W-1:0]                        n_freed;
    logic                                    dfe_hit;

    function automatic logic [CNT_W-1:0] popcount(input logic [PHYS_REG_SZ-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < PHYS_REG_SZ; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Grant selection: each requesting lane takes the highest remaining free
    // tag; rollback and reset suppress all grants.
    always_comb begin : p_grant
        logic [PHYS_REG_SZ-1:0] avail;
        logic                   found;
        avail        = free_map_q;
        grant_c      = '0;
        idx_c        = '0;
        granted_bits = '0;
        n_grant      = '0;
        found        = 1'b0;
        if (reset_n && !fl.rollback) begin
            for (int lane = 0; lane < ALLOC_WIDTH; lane++) begin
                found = 1'b0;
                if (fl.alloc_req[lane]) begin
                    for (int i = PHYS_REG_SZ - 1; i >= 0; i--) begin
                        if (!found && avail[i]) begin
                            found           = 1'b1;
                            avail[i]        = 1'b0;
                            granted_bits[i] = 1'b1;
                            grant_c[lane]   = 1'b1;
                            idx_c[lane*PHYS_REG_ID_BITS +: PHYS_REG_ID_BITS] =
                                PHYS_REG_ID_BITS'(i);
                        end
                    end
                    if (found) begin
                        n_grant = n_grant + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Release filtering: a free is legal only if the tag is not already free
    // (after this cycle's grants) and no lower lane freed it this cycle.
    // Checking against the post-grant map lets a free win over a same-cycle
    // grant of the same tag without flagging it as a double free.
    always_comb begin : p_free
        logic [PHYS_REG_SZ-1:0]      after_grant;
        logic [PHYS_REG_ID_BITS-1:0] tag;
        after_grant = free_map_q & ~granted_bits;
        freed_bits  = '0;
        n_freed     = '0;
        dfe_hit     = 1'b0;
        tag         = '0;
        if (!fl.rollback) begin
            for (int lane = 0; lane < FREE_WIDTH; lane++) begin
                tag = fl.free_idx[lane*PHYS_REG_ID_BITS +: PHYS_REG_ID_BITS];
                if (fl.free_valid[lane]) begin
                    if (after_grant[tag] || freed_bits[tag]) begin
                        dfe_hit = 1'b1;
                    end else begin
                        freed_bits[tag] = 1'b1;
                        n_freed         = n_freed + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Next-state: rollback reloads the checkpoint, otherwise grants clear and
    // legal frees set bits. The error flag is sticky until reset.
    always_comb begin : p_next
        free_map_d   = free_map_q;
        free_count_d = free_count_q;
        dfe_d        = dfe_q | dfe_hit;
        if (fl.rollback) begin
            free_map_d   = fl.rollback_map;
            free_count_d = popcount(fl.rollback_map);
        end else begin
            free_map_d   = (free_map_q & ~granted_bits) | freed_bits;
            free_count_d = free_count_q - n_grant + n_freed;
        end
        empty_d = (free_count_d == '0);
    end

    // State registers with asynchronous return to the initial mapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            free_map_q   <= RESET_MAP;
            free_count_q <= RESET_CNT;
            empty_q      <= (RESET_CNT == '0);
            dfe_q        <= 1'b0;
        end else begin
            free_map_q   <= free_map_d;
            free_count_q <= free_count_d;
            empty_q      <= empty_d;
            dfe_q        <= dfe_d;
        end
    end

    assign fl.alloc_grant     = grant_c;
    assign fl.alloc_idx       = idx_c;
    assign fl.free_map        = free_map_q;
    assign fl.free_count      = free_count_q;
    assign fl.empty           = empty_q;
    assign fl.double_free_err = dfe_q;

endmodule
